// File: rtl/data_memory_be.sv
// Byte-enabled 32-bit data memory with a fixed-latency request/done handshake.
// Loads are sign- or zero-extended; bad alignment, bad size or out-of-range addresses flag err_o.
module data_memory_be #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [31:0]       mem [DEPTH];

  logic              we_p0, uns_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic              op_we, op_uns, op_err, enter_done;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  op_idx;

  function automatic logic addr_error(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({1'b0, addr} >= MEM_BYTES) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic is_unsigned);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[8*lane +: 8];
    h = word[16*lane[1] +: 16];
    case (size)
      2'b00:   res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] res;
    res = old;
    case (size)
      2'b00:   res[8*lane +: 8] = wdata[7:0];
      2'b01:   res[16*lane[1] +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // With zero latency the accept edge is also the DONE-entry edge, so the live inputs are used
  always_comb begin
    op_we    = ready_o ? we_i       : we_p0;
    op_uns   = ready_o ? unsigned_i : uns_p0;
    op_size  = ready_o ? size_i     : size_p0;
    op_addr  = ready_o ? addr_i     : addr_p0;
    op_wdata = ready_o ? wdata_i    : wdata_p0;
    op_idx   = op_addr[IDX_W+1:2];
    op_err   = addr_error(op_size, op_addr);
    enter_done = (state != DONE) && (state_nxt == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_i) begin
        cnt_nxt   = LAT;
        state_nxt = (LATENCY == 0) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    done_o  = (state == DONE);
    err_o   = (state == DONE) && addr_error(size_p0, addr_p0);
  end

  // Accept stage: command capture
  always_ff @(posedge clk_i) begin
    if (ready_o && req_i) begin
      we_p0    <= we_i;
      uns_p0   <= unsigned_i;
      size_p0  <= size_i;
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
    end
  end

  // Completion stage: memory update and load result
  always_ff @(posedge clk_i) begin
    if (enter_done && op_we && !op_err)
      mem[op_idx] <= store_merge(mem[op_idx], op_wdata, op_addr[1:0], op_size);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (enter_done) begin
      if (op_err)      rdata_o <= '0;
      else if (!op_we) rdata_o <= load_extend(mem[op_idx], op_addr[1:0], op_size, op_uns);
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: directed vector table, reset-abort and back-to-back sequences,
// then random traffic against a byte-array reference model.
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        b_req = 1'b0, b_we = 1'b0, b_uns = 1'b0;
  logic [1:0]  b_size = 2'd0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_done, b_err;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_be #(.DEPTH(256), .ADDR_W(32), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .ready_o(ready), .done_o(done), .rdata_o(rdata), .err_o(err));

  data_memory_be #(.DEPTH(256), .ADDR_W(32), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(b_we), .size_i(b_size), .unsigned_i(b_uns),
    .addr_i(b_addr), .wdata_i(b_wdata), .ready_o(b_ready), .done_o(b_done), .rdata_o(b_rdata),
    .err_o(b_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns the result, latency in cycles and done_o one cycle later.
  task automatic access(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output logic done_after);
    int k;
    k = 0;
    while (!ready && k < 50) begin @(negedge clk); k++; end
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = $urandom; size = 2'($urandom); uns = $urandom; addr = $urandom; wdata = $urandom;
    lat = -1;
    for (k = 0; k < 50; k++) begin
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    rd = rdata;
    er = err;
    @(negedge clk);
    done_after = done;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [20];

  logic [7:0] mb [1024];

  function automatic bit m_err(input int unsigned s, input int unsigned a);
    return (s == 3) || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0) || (a >= 1024);
  endfunction

  function automatic logic [31:0] m_load(input int unsigned s, input int unsigned a, input bit u);
    longint v;
    int n;
    n = 1 << s;
    v = 0;
    for (int j = 0; j < n; j++) v += longint'(mb[a+j]) << (8*j);
    if (!u && n < 4 && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, d;
    logic        er, da, r;
    int          lat, acc, cyc[3];
    int unsigned a, s;
    bit          w, u, me;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h000, 32'h0BADF00D, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h011, 32'h123456A5, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h011, 32'h0,        32'h000000A5, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h011, 32'h0,        32'hFFFFFFA5, 1'b0};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADA5EF, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h013, 32'h0,        32'h00000000, 1'b1};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADA5EF, 1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h400, 32'h11111111, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h000, 32'h0,        32'h0BADF00D, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 32'h010, 32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADA5EF, 1'b0};
    tbl[13] = '{1'b0, 2'd1, 1'b1, 32'h012, 32'h0,        32'h0000DEAD, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[15] = '{1'b1, 2'd1, 1'b0, 32'h012, 32'hABCD1234, 32'hFFFFDEAD, 1'b0};
    tbl[16] = '{1'b0, 2'd1, 1'b0, 32'h012, 32'h0,        32'h00001234, 1'b0};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'h1234A5EF, 1'b0};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 32'h011, 32'h0,        32'h00000000, 1'b1};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 32'h013, 32'h0,        32'h00000012, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_rdata", rdata,      32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, da);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_done_pulse", i), 32'(da), 32'd0);
    end

    // Reset during WAIT of a store aborts it
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er, lat, da);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, da);
    chk("abort_prior", rd, 32'h11223344);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    chk("abort_in_wait", 32'(ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("abort_hold_done",  32'(done),  32'd0);
    chk("abort_hold_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, da);
    chk("abort_no_write", rd, 32'h11223344);

    // Back-to-back: req held 12 cycles
    acc = 0;
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      r = ready;
      @(negedge clk);
      if (r) begin
        if (acc < 3) cyc[acc] = i;
        acc++;
      end
    end
    req = 1'b0;
    chk("hold_accepts", 32'(acc), 32'd3);
    chk("hold_gap1", 32'(cyc[1] - cyc[0]), 32'd4);
    chk("hold_gap2", 32'(cyc[2] - cyc[1]), 32'd4);
    chk("hold_rdata", rdata, 32'h1234A5EF);
    for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
    chk("hold_idle", 32'(ready), 32'd1);

    // Zero-latency build
    b_req = 1'b1; b_we = 1'b1; b_size = 2'd2; b_addr = 32'h8; b_wdata = 32'hCAFEF00D;
    @(negedge clk);
    b_req = 1'b0;
    chk("lat0_done", 32'(b_done), 32'd1);
    chk("lat0_err",  32'(b_err),  32'd0);
    @(negedge clk);
    chk("lat0_ready", 32'(b_ready), 32'd1);
    chk("lat0_done_low", 32'(b_done), 32'd0);
    acc = 0;
    b_req = 1'b1; b_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = b_ready;
      @(negedge clk);
      if (r) begin
        if (acc < 3) cyc[acc] = i;
        acc++;
        chk("lat0_hold_done", 32'(b_done), 32'd1);
      end
    end
    b_req = 1'b0;
    chk("lat0_accepts", 32'(acc), 32'd3);
    chk("lat0_gap", 32'(cyc[2] - cyc[0]), 32'd4);
    chk("lat0_rdata", b_rdata, 32'hCAFEF00D);

    // Random traffic against the reference model
    access(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd, er, lat, da);
    chk("rnd_clear_rdata", rd, 32'd0);
    chk("rnd_clear_err", 32'(er), 32'd1);
    exp_rd = '0;
    for (int wi = 0; wi < 256; wi++) begin
      d = $urandom;
      access(1'b1, 2'd2, 1'b0, 32'(4*wi), d, rd, er, lat, da);
      for (int j = 0; j < 4; j++) mb[4*wi+j] = d[8*j +: 8];
      chk("init_err", 32'(er), 32'd0);
      chk("init_rdata", rd, exp_rd);
    end
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      u = 1'($urandom);
      s = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(1024, 70000) : $urandom_range(0, 1023);
      if ($urandom_range(0, 1) && s < 3) a = a & ~((32'd1 << s) - 1);
      d = $urandom;
      me = m_err(s, a);
      access(w, 2'(s), u, a, d, rd, er, lat, da);
      if (me) exp_rd = '0;
      else if (w) for (int j = 0; j < (1 << s); j++) mb[a+j] = d[8*j +: 8];
      else exp_rd = m_load(s, a, u);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(me));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
